// File: rtl/ps2tx.sv
// PS/2 host-to-device transmitter.
// The host pulls the clock line low for a request-to-send period. It then
// releases the clock and shifts out start, 8 data bits (LSB first), odd
// parity and stop, changing data only after each device clock fall. It
// samples the device ACK and watches for a stalled device clock.
//
// Handshake: wr_ps2 is a one-cycle request. It is accepted only while
// tx_idle = 1 and is dropped otherwise. Each frame ends with exactly one of
// tx_done_tick or tx_err_tick; a reset mid-frame ends it with neither.
module ps2tx #(
  parameter int RTS_CYCLES     = 12000,
  parameter int DLOW_CYCLES    = 200,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_pull_low,
  output logic       ps2d_pull_low,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick,
  output logic [2:0] fsm_state
);

  localparam int CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] RTS_LOAD = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] DLOW_V   = CW'(DLOW_CYCLES);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RTS   = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    ACK   = 3'd5
  } state_t;

  state_t        state;
  logic [7:0]    filt;
  logic          filt_val;
  logic          filt_next;
  logic          fall;
  logic [8:0]    frame;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wdog;

  assign tx_idle   = (state == IDLE);
  assign fsm_state = state;

  // Filtered clock level: changes only once all eight samples agree.
  always_comb begin
    filt_next = filt_val;
    if (filt == 8'hFF)
      filt_next = 1'b1;
    else if (filt == 8'h00)
      filt_next = 1'b0;
  end

  // Clock line sampling shift register and registered fall detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt     <= 8'hFF;
      filt_val <= 1'b1;
      fall     <= 1'b0;
    end else begin
      filt     <= {ps2c_in, filt[7:1]};
      filt_val <= filt_next;
      fall     <= filt_val & ~filt_next;
    end
  end

  // Frame sequencer with request-to-send timer and device-clock watchdog.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ps2c_pull_low <= 1'b0;
      ps2d_pull_low <= 1'b0;
      tx_done_tick  <= 1'b0;
      tx_err_tick   <= 1'b0;
      frame         <= '1;
      bit_cnt       <= '0;
      cnt           <= '0;
      wdog          <= '0;
    end else begin
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
      case (state)
        IDLE: begin
          ps2c_pull_low <= 1'b0;
          ps2d_pull_low <= 1'b0;
          // A fall in the same cycle is irrelevant here: IDLE ignores falls.
          if (wr_ps2) begin
            frame         <= {~^din, din};
            cnt           <= RTS_LOAD;
            ps2c_pull_low <= 1'b1;
            ps2d_pull_low <= (RTS_LOAD < DLOW_V);
            state         <= RTS;
          end
        end
        RTS: begin
          if (cnt == '0) begin
            ps2c_pull_low <= 1'b0;
            ps2d_pull_low <= 1'b1;
            wdog          <= '0;
            state         <= START;
          end else begin
            cnt           <= cnt - CW'(1);
            ps2d_pull_low <= ((cnt - CW'(1)) < DLOW_V);
          end
        end
        START, DATA, STOP, ACK: begin
          if (fall) begin
            wdog <= '0;
            case (state)
              START: begin
                ps2d_pull_low <= ~frame[0];
                bit_cnt       <= 4'd8;
                state         <= DATA;
              end
              DATA: begin
                if (bit_cnt == 4'd0) begin
                  ps2d_pull_low <= 1'b0;
                  state         <= STOP;
                end else begin
                  frame         <= {1'b1, frame[8:1]};
                  ps2d_pull_low <= ~frame[1];
                  bit_cnt       <= bit_cnt - 4'd1;
                end
              end
              STOP: begin
                ps2d_pull_low <= 1'b0;
                state         <= ACK;
              end
              ACK: begin
                if (ps2d_in)
                  tx_err_tick <= 1'b1;
                else
                  tx_done_tick <= 1'b1;
                state <= IDLE;
              end
              default: state <= IDLE;
            endcase
          end else if (wdog == WD_LAST) begin
            // Device clock stalled: give the bus back and report.
            tx_err_tick   <= 1'b1;
            ps2c_pull_low <= 1'b0;
            ps2d_pull_low <= 1'b0;
            state         <= IDLE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: begin
          ps2c_pull_low <= 1'b0;
          ps2d_pull_low <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2tx.sv
// Testbench for ps2tx: an open-drain bus model with a behavioural keyboard
// that clocks frames, samples the host data on each rising edge and
// optionally ACKs. Results are compared with frames built from the byte
// value, its parity and the expected ACK outcome.
module tb_ps2tx;

  localparam int RTS  = 120;
  localparam int DLOW = 20;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_pull_low;
  logic       ps2d_pull_low;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;
  logic [2:0] fsm_state;

  logic dev_clk;
  logic dev_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;
  bit both_seen = 0;
  int c_run = 0;
  int d_run = 0;
  int c_len = 0;
  int d_len = 0;
  logic c_prev = 1'b0;

  logic [11:0] exp_q[$];

  // Open-drain wired-AND of host and device drivers.
  assign ps2c_in = dev_clk & ~ps2c_pull_low;
  assign ps2d_in = dev_data & ~ps2d_pull_low;

  ps2tx #(
    .RTS_CYCLES    (RTS),
    .DLOW_CYCLES   (DLOW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_pull_low(ps2c_pull_low),
    .ps2d_pull_low(ps2d_pull_low),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_err_tick  (tx_err_tick),
    .fsm_state    (fsm_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Tick counting and clock-low / data-low run lengths during request-to-send.
  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (tx_err_tick) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (tx_done_tick && tx_err_tick) both_seen = 1;
    if (ps2c_pull_low) begin
      if (!c_prev) begin
        c_run = 0;
        d_run = 0;
      end
      c_run++;
      if (ps2d_pull_low) d_run++;
    end else if (c_prev) begin
      c_len = c_run;
      d_len = d_run;
    end
    c_prev = ps2c_pull_low;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pull(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (ps2c_pull_low !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check(tag, {31'd0, ps2c_pull_low}, {31'd0, lvl});
  endtask

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
  endtask

  // Line values seen by the device at each rising edge after falls 1..12:
  // data LSB first, odd parity, stop, released line, then its own ACK level.
  function automatic logic [11:0] exp_line(input logic [7:0] b, input bit ack_low);
    int ones;
    logic [11:0] r;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i];
      if (b[i]) ones++;
    end
    r[8]  = (ones % 2 == 0);
    r[9]  = 1'b1;
    r[10] = 1'b1;
    r[11] = ack_low ? 1'b0 : 1'b1;
    return r;
  endfunction

  // Keyboard model: optional wait for request-to-send, then nfalls clock pulses.
  task automatic run_device(input bit wait_rts, input int nfalls, input bit ack_low,
                            output logic [11:0] line, output logic start_line);
    line = '1;
    if (wait_rts) begin
      wait_pull(1'b1, 50, "rts_begin");
      wait_pull(1'b0, RTS + 50, "rts_end");
    end
    wait_cycles(HALF);
    start_line = ps2d_in;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 12) dev_data = ack_low ? 1'b0 : 1'b1;
      @(negedge clk);
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      line[k-1] = ps2d_in;
      wait_cycles(HALF);
    end
    dev_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack_low, input string tag);
    int d0, e0;
    logic [11:0] line;
    logic sl;
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(exp_line(b, ack_low));
    request(b);
    run_device(1'b1, 12, ack_low, line, sl);
    wait_cycles(20);
    check({tag, "_start"}, {31'd0, sl}, 32'd0);
    check({tag, "_frame"}, {20'd0, line}, {20'd0, exp_q.pop_front()});
    check({tag, "_done"}, done_cnt - d0, ack_low ? 32'd1 : 32'd0);
    check({tag, "_err"}, err_cnt - e0, ack_low ? 32'd0 : 32'd1);
    check({tag, "_idle"}, {31'd0, tx_idle}, 32'd1);
  endtask

  initial begin
    logic [11:0] line;
    logic sl;
    logic [7:0] b;
    bit ack;
    int d0, e0, n;

    reset    = 1'b0;
    wr_ps2   = 1'b0;
    din      = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;

    // Reset state.
    wait_cycles(5);
    check("rst_c", {31'd0, ps2c_pull_low}, 32'd0);
    check("rst_d", {31'd0, ps2d_pull_low}, 32'd0);
    check("rst_idle", {31'd0, tx_idle}, 32'd1);
    check("rst_ticks", {30'd0, tx_done_tick, tx_err_tick}, 32'd0);
    reset = 1'b1;
    wait_cycles(5);

    // 0xED with ACK: request-to-send timing and frame content.
    do_frame(8'hED, 1'b1, "ed");
    check("rts_len", c_len, RTS);
    check("dlow_len", d_len, DLOW);

    // 0x00 without ACK: parity 1, error tick only.
    do_frame(8'h00, 1'b0, "zero_nak");

    // Device stalls after the 4th fall: watchdog error.
    b  = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    request(b);
    run_device(1'b1, 4, 1'b1, line, sl);
    n = 0;
    while (err_cnt == e0 && n < TO + 200) begin
      @(negedge clk);
      n++;
    end
    check("to_err", err_cnt - e0, 32'd1);
    check("to_delay_ok", {31'd0, (err_cyc - last_fall_cyc >= TO) &&
                                 (err_cyc - last_fall_cyc <= TO + 16)}, 32'd1);
    check("to_bits", {28'd0, line[3:0]}, {28'd0, b[3:0]});
    check("to_pulls", {30'd0, ps2c_pull_low, ps2d_pull_low}, 32'd0);
    check("to_idle", {31'd0, tx_idle}, 32'd1);
    check("to_done", done_cnt - d0, 32'd0);

    // Second request during DATA is ignored.
    d0 = done_cnt;
    e0 = err_cnt;
    exp_q.push_back(exp_line(8'hED, 1'b1));
    request(8'hED);
    fork
      run_device(1'b1, 12, 1'b1, line, sl);
      begin
        wait_cycles(RTS + HALF + 4 * 2 * HALF);
        check("busy_idle", {31'd0, tx_idle}, 32'd0);
        request(8'hFF);
      end
    join
    wait_cycles(20);
    check("ovr_frame", {20'd0, line}, {20'd0, exp_q.pop_front()});
    check("ovr_done", done_cnt - d0, 32'd1);
    check("ovr_err", err_cnt - e0, 32'd0);

    // Asynchronous reset during DATA, then a normal 0xF4 frame.
    d0 = done_cnt;
    e0 = err_cnt;
    request(8'hED);
    run_device(1'b1, 5, 1'b1, line, sl);
    check("pre_rst_d_pull", {31'd0, ps2d_pull_low}, {31'd0, ~line[4]});
    @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_pulls", {30'd0, ps2c_pull_low, ps2d_pull_low}, 32'd0);
    check("arst_idle", {31'd0, tx_idle}, 32'd1);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    check("arst_ticks", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    do_frame(8'hF4, 1'b1, "f4");

    // Three-cycle clock glitch in START is filtered out.
    b = 8'($urandom);
    d0 = done_cnt;
    exp_q.push_back(exp_line(b, 1'b1));
    request(b);
    wait_pull(1'b1, 50, "g_rts_begin");
    wait_pull(1'b0, RTS + 50, "g_rts_end");
    wait_cycles(10);
    dev_clk = 1'b0;
    wait_cycles(3);
    dev_clk = 1'b1;
    wait_cycles(20);
    check("glitch_d", {31'd0, ps2d_pull_low}, 32'd1);
    check("glitch_busy", {31'd0, tx_idle}, 32'd0);
    run_device(1'b0, 12, 1'b1, line, sl);
    wait_cycles(20);
    check("glitch_frame", {20'd0, line}, {20'd0, exp_q.pop_front()});
    check("glitch_done", done_cnt - d0, 32'd1);

    // Random bytes and ACK outcomes.
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom_range(0, 255));
      ack = 1'($urandom_range(0, 1));
      do_frame(b, ack, "rnd");
    end

    check("never_both_ticks", {31'd0, both_seen}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
